fifo_stream_reader: RTL

Read-side controller for the synchronous byte FIFO (`Sync_FIFO`). It drains the FIFO through its `rd_en`/`buf_empty`/`buf_out` port and absorbs the one-cycle registered read latency. Each byte is presented to a downstream consumer on a valid/ready stream, with a 2-entry skid buffer so no popped byte is ever lost. It replaces the hand-written pop task used on the bench and sits between the FIFO and any byte sink (serializer, packetizer).

---
 rtl/fifo_stream_reader.sv | 73 +++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader
// Purpose  : Drains a synchronous byte FIFO (1-cycle registered read data)
//            onto a valid/ready stream through a 2-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  buf_empty,
  input  logic [DATA_WIDTH-1:0] buf_out,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  pop_count,
  output logic                  idle
);

  logic [DATA_WIDTH-1:0] r_entry [2];
  logic                  r_head;
  logic                  r_tail;
  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [CNT_WIDTH-1:0]  r_pop_count;

  logic                  w_accept;
  logic [2:0]            w_pending;

  assign w_accept = m_valid && m_ready;

  // Entries that will be held after this edge if no new pop is issued; a pop
  // is allowed only while that leaves room for the byte it will return.
  assign w_pending = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_accept};
  assign rd_en     = en && !buf_empty && (w_pending < 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_entry[0]  <= '0;
      r_entry[1]  <= '0;
      r_head      <= 1'b0;
      r_tail      <= 1'b0;
      r_occ       <= 2'd0;
      r_inflight  <= 1'b0;
      r_pop_count <= '0;
    end else begin
      r_inflight <= rd_en;
      if (rd_en) begin
        r_pop_count <= r_pop_count + 1'b1;
      end
      if (r_inflight) begin
        r_entry[r_tail] <= buf_out;
        r_tail          <= ~r_tail;
      end
      if (w_accept) begin
        r_head <= ~r_head;
      end
      r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_accept};
    end
  end

  assign m_valid   = (r_occ != 2'd0);
  assign m_data    = r_entry[r_head];
  assign pop_count = r_pop_count;
  assign idle      = (r_occ == 2'd0) && !r_inflight && buf_empty;

endmodule
`default_nettype wire
